// File: rtl/addr_router_pkg.sv
// Shared types and the address-to-channel decode function for addr_router.
package addr_router_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   // Upper bound on channel count the decode function can describe.
   localparam int MAX_CH = 256;

   typedef struct packed {
      logic              mapped;
      logic [MAX_CH-1:0] onehot;
   } dec_t;

   // Channel i answers to address i+1; address 0 and anything past num_ch are unmapped.
   function automatic dec_t decode_addr(input logic [31:0] addr, input int num_ch);
      dec_t r;
      r = '0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (i < num_ch && addr == 32'(i + 1)) begin
            r.onehot[i] = 1'b1;
            r.mapped    = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/addr_router_decode.sv
// Combinational address decoder: one-hot channel select plus a mapped flag.
module addr_decode
   import addr_router_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int NUM_CH = 2
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [NUM_CH-1:0] onehot,
   output logic              mapped
);

   dec_t dec;

   assign dec    = decode_addr(32'(addr), NUM_CH);
   assign onehot = dec.onehot[NUM_CH-1:0];
   // Upper bits are zero by construction; folding them in keeps the whole result consumed.
   assign mapped = dec.mapped & ~|dec.onehot[MAX_CH-1:NUM_CH];

endmodule

// File: rtl/addr_router.sv
// Single-outstanding address router: decode, hold a one-hot enable until ACK or
// timeout, then return a one-cycle response with read data or an error.
module addr_router
   import addr_router_pkg::*;
#(
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 8,
   parameter int NUM_CH  = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                     CLK,
   input  logic                     RESETN,
   input  logic                     REQ_VALID,
   output logic                     REQ_READY,
   input  logic                     REQ_WRITE,
   input  logic [ADDR_W-1:0]        REQ_ADDR,
   input  logic [DATA_W-1:0]        REQ_WDATA,
   output logic [NUM_CH-1:0]        CH_EN,
   output logic                     CH_WRITE,
   output logic [DATA_W-1:0]        CH_WDATA,
   input  logic [NUM_CH-1:0]        CH_ACK,
   input  logic [NUM_CH*DATA_W-1:0] CH_RDATA,
   output logic                     RSP_VALID,
   output logic                     RSP_ERR,
   output logic [DATA_W-1:0]        RSP_RDATA
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_CH-1:0]   ch_en_q, ch_en_d;
   logic                ch_write_q, ch_write_d;
   logic [DATA_W-1:0]   ch_wdata_q, ch_wdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

   logic [NUM_CH-1:0]   dec_onehot;
   logic                dec_mapped;
   logic                ack_hit;
   logic                timeout_hit;
   logic [DATA_W-1:0]   sel_rdata;

   addr_decode #(
      .ADDR_W (ADDR_W),
      .NUM_CH (NUM_CH)
   ) u_decode (
      .addr   (REQ_ADDR),
      .onehot (dec_onehot),
      .mapped (dec_mapped)
   );

   // The held enable doubles as the latched channel select while BUSY.
   assign ack_hit     = |(CH_ACK & ch_en_q);
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_en_q[i]) sel_rdata = sel_rdata | CH_RDATA[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ch_en_d     = ch_en_q;
      ch_write_d  = ch_write_q;
      ch_wdata_d  = ch_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      case (state_q)
         IDLE: begin
            if (REQ_VALID) begin
               ch_write_d = REQ_WRITE;
               ch_wdata_d = REQ_WDATA;
               cnt_d      = '0;
               if (dec_mapped) begin
                  ch_en_d = dec_onehot;
                  state_d = BUSY;
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            // ACK takes priority over a timeout landing in the same cycle.
            if (ack_hit) begin
               state_d     = RESP;
               ch_en_d     = '0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = ch_write_q ? '0 : sel_rdata;
            end else if (timeout_hit) begin
               state_d     = RESP;
               ch_en_d     = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: begin
            state_d = IDLE;
            ch_en_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ch_en_q     <= '0;
         ch_write_q  <= 1'b0;
         ch_wdata_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ch_en_q     <= ch_en_d;
         ch_write_q  <= ch_write_d;
         ch_wdata_q  <= ch_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign REQ_READY = (state_q == IDLE);
   assign CH_EN     = ch_en_q;
   assign CH_WRITE  = ch_write_q;
   assign CH_WDATA  = ch_wdata_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_ERR   = rsp_err_q;
   assign RSP_RDATA = rsp_rdata_q;

endmodule

// File: tb/tb_addr_router.sv
// Directed bench for addr_router: a default 2-channel instance and a 4-channel instance.
module tb_addr_router;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   // NUM_CH = 2 instance
   logic        v2, rdy2, w2, cw2, rv2, re2;
   logic [2:0]  a2;
   logic [7:0]  wd2, cwd2, rr2;
   logic [1:0]  en2, ack2;
   logic [15:0] rd2;

   // NUM_CH = 4 instance
   logic        v4, rdy4, w4, cw4, rv4, re4;
   logic [2:0]  a4;
   logic [7:0]  wd4, cwd4, rr4;
   logic [3:0]  en4, ack4;
   logic [31:0] rd4;

   int vec  = 0;
   int errs = 0;

   addr_router u_dut2 (
      .CLK(clk), .RESETN(rstn), .REQ_VALID(v2), .REQ_READY(rdy2), .REQ_WRITE(w2),
      .REQ_ADDR(a2), .REQ_WDATA(wd2), .CH_EN(en2), .CH_WRITE(cw2), .CH_WDATA(cwd2),
      .CH_ACK(ack2), .CH_RDATA(rd2), .RSP_VALID(rv2), .RSP_ERR(re2), .RSP_RDATA(rr2)
   );

   addr_router #(.NUM_CH(4)) u_dut4 (
      .CLK(clk), .RESETN(rstn), .REQ_VALID(v4), .REQ_READY(rdy4), .REQ_WRITE(w4),
      .REQ_ADDR(a4), .REQ_WDATA(wd4), .CH_EN(en4), .CH_WRITE(cw4), .CH_WDATA(cwd4),
      .CH_ACK(ack4), .CH_RDATA(rd4), .RSP_VALID(rv4), .RSP_ERR(re4), .RSP_RDATA(rr4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] bad_addr [3];
      logic [1:0] bad_dut  [3];
      int  cnt;
      int  pulses;
      bit  seen;

      rstn = 1'b0;
      v2 = 0; w2 = 0; a2 = 0; wd2 = 0; ack2 = 0; rd2 = 0;
      v4 = 0; w4 = 0; a4 = 0; wd4 = 0; ack4 = 0; rd4 = 0;
      #3;
      chk("rst_ready2", rdy2, 1); chk("rst_en2", en2, 0); chk("rst_cw2", cw2, 0);
      chk("rst_cwd2", cwd2, 0);   chk("rst_rv2", rv2, 0); chk("rst_re2", re2, 0);
      chk("rst_rr2", rr2, 0);     chk("rst_ready4", rdy4, 1); chk("rst_en4", en4, 0);
      #9 rstn = 1'b1;
      step();

      // Read channel 0 with ACK already high
      rd2 = 16'h5AA5; ack2 = 2'b01; v2 = 1; w2 = 0; a2 = 3'd1;
      chk("rd_ready_pre", rdy2, 1);
      step(); v2 = 0;
      chk("rd_en", en2, 2'b01); chk("rd_busy_ready", rdy2, 0); chk("rd_rv_early", rv2, 0);
      step();
      chk("rd_en_off", en2, 0); chk("rd_rv", rv2, 1); chk("rd_rdata", rr2, 8'hA5);
      chk("rd_err", re2, 0);    chk("rd_resp_ready", rdy2, 0);
      step(); ack2 = 0;
      chk("rd_rv_pulse", rv2, 0); chk("rd_idle_ready", rdy2, 1);

      // Write channel 3 of the 4-channel router, ACK in the 3rd busy cycle
      rd4 = 32'hDEADBEEF; v4 = 1; w4 = 1; a4 = 3'd4; wd4 = 8'h3C;
      for (int k = 1; k <= 3; k++) begin
         step();
         if (k == 1) v4 = 0;
         chk("wr_en", en4, 4'b1000); chk("wr_wdata", cwd4, 8'h3C);
         chk("wr_write", cw4, 1);    chk("wr_rv_early", rv4, 0);
         if (k == 3) ack4 = 4'b1000;
      end
      step(); ack4 = 0;
      chk("wr_en_off", en4, 0); chk("wr_rv", rv4, 1); chk("wr_err", re4, 0);
      chk("wr_rdata_zero", rr4, 0);
      step();
      chk("wr_rv_pulse", rv4, 0);

      // Unmapped addresses: 0 and 3 on the 2-channel router, 7 on the 4-channel one
      bad_addr[0] = 3'd0; bad_dut[0] = 2;
      bad_addr[1] = 3'd3; bad_dut[1] = 2;
      bad_addr[2] = 3'd7; bad_dut[2] = 0;
      for (int i = 0; i < 3; i++) begin
         if (bad_dut[i] == 2) begin v2 = 1; a2 = bad_addr[i]; w2 = 0; end
         else begin v4 = 1; a4 = bad_addr[i]; w4 = 0; end
         ack2 = 2'b11; ack4 = 4'b1111;
         step(); v2 = 0; v4 = 0;
         if (bad_dut[i] == 2) begin
            chk("unm_rv2", rv2, 1); chk("unm_err2", re2, 1); chk("unm_en2", en2, 0);
         end else begin
            chk("unm_rv4", rv4, 1); chk("unm_err4", re4, 1); chk("unm_en4", en4, 0);
         end
         step(); ack2 = 0; ack4 = 0;
         chk("unm_done_rv", {rv2, rv4}, 0); chk("unm_done_en", {en2, en4}, 0);
         chk("unm_ready", {rdy2, rdy4}, 2'b11);
      end

      // Timeout on channel 1 with no ACK
      rd2 = 16'h77A5; v2 = 1; a2 = 3'd2; w2 = 0;
      cnt = 0; seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step();
         if (k == 0) v2 = 0;
         if (en2 != 0) begin
            cnt++;
            if (en2 !== 2'b10) chk("to_en_val", en2, 2'b10);
         end
         if (rv2) begin
            seen = 1;
            chk("to_err", re2, 1); chk("to_rdata_zero", rr2, 0);
         end
      end
      chk("to_seen", seen, 1);
      chk("to_en_cycles", cnt, 15);
      step();

      // ACK arrives in the 15th busy cycle: ACK wins over timeout
      v2 = 1; a2 = 3'd2;
      step(); v2 = 0;
      repeat (14) step();
      chk("tack_en", en2, 2'b10); chk("tack_rv_early", rv2, 0);
      ack2 = 2'b10;
      step(); ack2 = 0;
      chk("tack_rv", rv2, 1); chk("tack_err", re2, 0); chk("tack_rdata", rr2, 8'h77);
      step();

      // Wrong-channel ACK ignored; request held through BUSY/RESP
      rd2 = 16'h1122; v2 = 1; a2 = 3'd1; w2 = 0;
      step();
      chk("wc_en", en2, 2'b01);
      ack2 = 2'b10;
      step();
      chk("wc_ignored_en", en2, 2'b01); chk("wc_ignored_rv", rv2, 0); chk("wc_ready", rdy2, 0);
      ack2 = 2'b01;
      step();
      chk("wc_rv", rv2, 1); chk("wc_rdata", rr2, 8'h22); chk("wc_held_ready", rdy2, 0);
      ack2 = 2'b00;
      step();
      chk("wc_idle_ready", rdy2, 1); chk("wc_not_accepted", en2, 0);
      step(); v2 = 0;
      chk("wc_held_accept", en2, 2'b01);
      ack2 = 2'b01;
      step(); ack2 = 0;
      chk("wc2_rv", rv2, 1);
      step();

      // Reset during the 2nd busy cycle
      v4 = 1; a4 = 3'd2; w4 = 0;
      step(); v4 = 0;
      step();
      chk("rb_en_busy", en4, 4'b0010);
      #2 rstn = 1'b0;
      #1;
      chk("rb_en_async", en4, 0); chk("rb_ready", rdy4, 1);
      #4 rstn = 1'b1;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (rv4) pulses++;
      end
      chk("rb_no_rsp", pulses, 0);
      chk("rb_ready_after", rdy4, 1);
      chk("rb_en_after", en4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
